hack_cpu: RTL and testbench

Single-cycle Hack CPU datapath and control that sits directly around the 16-bit ALU. It decodes A/C instructions, holds the A and D registers and the PC, and drives the ALU's six control bits and x/y operands. It consumes the ALU result to produce the memory write (outM/writeM/addressM), the zr/ng flags and the jump decision. Instruction ROM and data RAM are external.

---
 rtl/hack_cpu_pkg.sv | 49 ++++
 rtl/hack_alu.sv | 36 +++
 rtl/hack_jump_unit.sv | 27 ++
 rtl/hack_cpu.sv | 106 ++++++++++
 tb/tb_hack_cpu.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/hack_cpu_pkg.sv
// ============================================================================
// hack_cpu_pkg : shared instruction-field positions, types and decode helper
// Rev 1.0
// ============================================================================
`default_nettype none

package hack_cpu_pkg;

    localparam int A_BIT   = 15;
    localparam int A_SEL   = 12;
    localparam int COMP_HI = 11;
    localparam int COMP_LO = 6;
    localparam int DEST_A  = 5;
    localparam int DEST_D  = 4;
    localparam int DEST_M  = 3;
    localparam int J_LT    = 2;
    localparam int J_EQ    = 1;
    localparam int J_GT    = 0;

    localparam logic [14:0] DEFAULT_RESET_PC = 15'h0000;

    typedef enum logic {
        INSTR_A = 1'b0,
        INSTR_C = 1'b1
    } instr_kind_e;

    typedef struct packed {
        logic       a_sel;
        logic [5:0] comp;
        logic       dest_a;
        logic       dest_d;
        logic       dest_m;
        logic [2:0] jump;
    } c_fields_t;

    function automatic c_fields_t decode_c(input logic [15:0] instr);
        c_fields_t f;
        f.a_sel  = instr[A_SEL];
        f.comp   = instr[COMP_HI:COMP_LO];
        f.dest_a = instr[DEST_A];
        f.dest_d = instr[DEST_D];
        f.dest_m = instr[DEST_M];
        f.jump   = {instr[J_LT], instr[J_EQ], instr[J_GT]};
        return f;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hack_alu.sv
// ============================================================================
// hack_alu : 16-bit Hack ALU (zx/nx/zy/ny/f/no), purely combinational
// Rev 1.0
// ============================================================================
`default_nettype none

module hack_alu (
    input  logic [15:0] x_i,
    input  logic [15:0] y_i,
    input  logic        zx_i,
    input  logic        nx_i,
    input  logic        zy_i,
    input  logic        ny_i,
    input  logic        f_i,
    input  logic        no_i,
    output logic [15:0] out_o
);

    logic [15:0] w_x_z;
    logic [15:0] w_x_n;
    logic [15:0] w_y_z;
    logic [15:0] w_y_n;
    logic [15:0] w_f;

    always_comb begin
        w_x_z = zx_i ? 16'h0000 : x_i;
        w_x_n = nx_i ? ~w_x_z : w_x_z;
        w_y_z = zy_i ? 16'h0000 : y_i;
        w_y_n = ny_i ? ~w_y_z : w_y_z;
        w_f   = f_i ? (w_x_n + w_y_n) : (w_x_n & w_y_n);
        out_o = no_i ? ~w_f : w_f;
    end

endmodule

`default_nettype wire

// File: rtl/hack_jump_unit.sv
// ============================================================================
// hack_jump_unit : derives zr/ng flags from the ALU result and the jump decision
// Rev 1.0
// ============================================================================
`default_nettype none

module hack_jump_unit (
    input  logic [15:0] alu_out_i,
    input  logic [2:0]  j_i,
    output logic        zr_o,
    output logic        ng_o,
    output logic        take_o
);

    logic w_pos;

    always_comb begin
        zr_o   = (alu_out_i == 16'h0000);
        ng_o   = alu_out_i[15];
        w_pos  = !zr_o && !ng_o;
        // j_i is {jlt, jeq, jgt}
        take_o = (j_i[2] & ng_o) | (j_i[1] & zr_o) | (j_i[0] & w_pos);
    end

endmodule

`default_nettype wire

// File: rtl/hack_cpu.sv
// ============================================================================
// hack_cpu : single-cycle Hack CPU (A/D/PC registers, decode, ALU, jump)
// Rev 1.0
// ============================================================================
`default_nettype none

module hack_cpu
    import hack_cpu_pkg::*;
#(
    parameter int                WIDTH    = 16,
    parameter int                ADDR_W   = 15,
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [WIDTH-1:0]  instruction,
    input  logic [WIDTH-1:0]  inM,
    output logic [WIDTH-1:0]  outM,
    output logic              writeM,
    output logic [ADDR_W-1:0] addressM,
    output logic [ADDR_W-1:0] pc
);

    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  d_q, d_d;
    logic [ADDR_W-1:0] pc_q, pc_d;

    instr_kind_e      w_kind;
    c_fields_t        w_cf;
    logic             w_is_c;
    logic [WIDTH-1:0] w_y;
    logic [WIDTH-1:0] w_alu_out;
    logic             w_zr;
    logic             w_ng;
    logic             w_take;
    logic             w_jump;
    logic             w_unused;

    assign w_kind = instr_kind_e'(instruction[A_BIT]);
    assign w_cf   = decode_c(instruction);
    assign w_is_c = (w_kind == INSTR_C);
    assign w_y    = w_cf.a_sel ? inM : a_q;

    hack_alu u_alu (
        .x_i   (d_q),
        .y_i   (w_y),
        .zx_i  (w_cf.comp[5]),
        .nx_i  (w_cf.comp[4]),
        .zy_i  (w_cf.comp[3]),
        .ny_i  (w_cf.comp[2]),
        .f_i   (w_cf.comp[1]),
        .no_i  (w_cf.comp[0]),
        .out_o (w_alu_out)
    );

    hack_jump_unit u_jump (
        .alu_out_i (w_alu_out),
        .j_i       (w_cf.jump),
        .zr_o      (w_zr),
        .ng_o      (w_ng),
        .take_o    (w_take)
    );

    assign w_jump   = w_is_c & en & w_take;
    // Flags are only consumed through the jump decision; bits 14:13 are don't-care.
    assign w_unused = ^{w_zr, w_ng, instruction[14:13]};

    always_comb begin
        a_d  = a_q;
        d_d  = d_q;
        pc_d = pc_q;
        if (en) begin
            if (!w_is_c) begin
                a_d = instruction;
            end else if (w_cf.dest_a) begin
                a_d = w_alu_out;
            end
            if (w_is_c && w_cf.dest_d) begin
                d_d = w_alu_out;
            end
            // Jump target is the A value from before this edge, even if dA is set.
            pc_d = w_jump ? a_q[ADDR_W-1:0] : pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q  <= '0;
            d_q  <= '0;
            pc_q <= RESET_PC;
        end else begin
            a_q  <= a_d;
            d_q  <= d_d;
            pc_q <= pc_d;
        end
    end

    assign outM     = w_alu_out;
    assign writeM   = rst_n & en & w_is_c & w_cf.dest_m;
    assign addressM = a_q[ADDR_W-1:0];
    assign pc       = pc_q;

endmodule

`default_nettype wire

// File: tb/tb_hack_cpu.sv
// ============================================================================
// tb_hack_cpu : directed self-checking bench for hack_cpu
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_hack_cpu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic [15:0] instruction = 16'h0000;
    logic [15:0] inM = 16'h0000;
    logic [15:0] outM;
    logic        writeM;
    logic [14:0] addressM;
    logic [14:0] pc;

    int          total = 0;
    int          bad = 0;
    logic [14:0] pc_m = 15'h0000;

    hack_cpu #(
        .WIDTH    (16),
        .ADDR_W   (15),
        .RESET_PC (15'h0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .instruction (instruction),
        .inM         (inM),
        .outM        (outM),
        .writeM      (writeM),
        .addressM    (addressM),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exec(input logic [15:0] ins);
        instruction = ins;
        tick();
        pc_m = pc_m + 15'd1;
    endtask

    // Loads D with a 15-bit constant via A (D=A).
    task automatic load_d(input logic [15:0] v);
        exec(v);
        exec(16'hEC10);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b1;
        instruction = 16'hFFFF;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++; if (writeM !== 1'b0) begin bad++; $display("FAIL reset_writeM_pre%0d: got %b want 0", i, writeM); end
            tick();
            total++; if (pc !== 15'h0000) begin bad++; $display("FAIL reset_pc%0d: got %h want 0000", i, pc); end
            total++; if (addressM !== 15'h0000) begin bad++; $display("FAIL reset_addr%0d: got %h want 0000", i, addressM); end
            total++; if (writeM !== 1'b0) begin bad++; $display("FAIL reset_writeM%0d: got %b want 0", i, writeM); end
        end
        rst_n = 1'b1;
        pc_m = 15'h0000;
        instruction = 16'hE300;
        #1;
        total++; if (outM !== 16'h0000) begin bad++; $display("FAIL reset_D: got %h want 0000", outM); end
        total++; if (addressM !== 15'h0000) begin bad++; $display("FAIL reset_A: got %h want 0000", addressM); end
    endtask

    task automatic test_load();
        exec(16'h0005);
        total++; if (addressM !== 15'd5) begin bad++; $display("FAIL load_addr: got %h want 0005", addressM); end
        total++; if (pc !== 15'd1) begin bad++; $display("FAIL load_pc1: got %h want 0001", pc); end
        instruction = 16'hEC10;
        #1;
        total++; if (writeM !== 1'b0) begin bad++; $display("FAIL load_writeM: got %b want 0", writeM); end
        tick();
        pc_m = pc_m + 15'd1;
        total++; if (pc !== 15'd2) begin bad++; $display("FAIL load_pc2: got %h want 0002", pc); end
        instruction = 16'hE300;
        #1;
        total++; if (outM !== 16'd5) begin bad++; $display("FAIL load_D: got %h want 0005", outM); end
    endtask

    task automatic test_mem_write();
        load_d(16'h0005);
        exec(16'h0064);
        instruction = 16'hE7C8;
        #1;
        total++; if (outM !== 16'd6) begin bad++; $display("FAIL memw_outM: got %h want 0006", outM); end
        total++; if (writeM !== 1'b1) begin bad++; $display("FAIL memw_writeM: got %b want 1", writeM); end
        total++; if (addressM !== 15'd100) begin bad++; $display("FAIL memw_addr: got %h want 0064", addressM); end
        tick();
        pc_m = pc_m + 15'd1;
        total++; if (pc !== pc_m) begin bad++; $display("FAIL memw_pc: got %h want %h", pc, pc_m); end
        instruction = 16'hE300;
        #1;
        total++; if (outM !== 16'd5) begin bad++; $display("FAIL memw_D_kept: got %h want 0005", outM); end
        inM = 16'h1234;
        instruction = 16'hFC10;
        #1;
        total++; if (outM !== 16'h1234) begin bad++; $display("FAIL memw_y_inM: got %h want 1234", outM); end
        inM = 16'h0000;
        instruction = 16'hE7E8;
        #1;
        total++; if (writeM !== 1'b1 || addressM !== 15'd100 || outM !== 16'd6) begin
            bad++; $display("FAIL memw_AM: got we=%b addr=%h out=%h want 1/0064/0006", writeM, addressM, outM);
        end
        tick();
        pc_m = pc_m + 15'd1;
        total++; if (addressM !== 15'd6) begin bad++; $display("FAIL memw_AM_newA: got %h want 0006", addressM); end
    endtask

    task automatic test_jump();
        exec(16'hEA90);
        exec(16'h0010);
        instruction = 16'hE302;
        tick();
        pc_m = 15'h0010;
        total++; if (pc !== 15'h0010) begin bad++; $display("FAIL jeq_taken: got %h want 0010", pc); end
        load_d(16'h0005);
        exec(16'h0010);
        instruction = 16'hE302;
        tick();
        pc_m = pc_m + 15'd1;
        total++; if (pc !== pc_m) begin bad++; $display("FAIL jeq_not_taken: got %h want %h", pc, pc_m); end
        instruction = 16'hEA87;
        tick();
        pc_m = 15'h0010;
        total++; if (pc !== 15'h0010) begin bad++; $display("FAIL jmp: got %h want 0010", pc); end
        exec(16'hEE90);
        exec(16'h0020);
        instruction = 16'hE301;
        tick();
        pc_m = pc_m + 15'd1;
        total++; if (pc !== pc_m) begin bad++; $display("FAIL jgt_neg: got %h want %h", pc, pc_m); end
        instruction = 16'hE304;
        tick();
        pc_m = 15'h0020;
        total++; if (pc !== 15'h0020) begin bad++; $display("FAIL jlt_neg: got %h want 0020", pc); end
        exec(16'h0030);
        instruction = 16'hEFE7;
        tick();
        pc_m = 15'h0030;
        total++; if (pc !== 15'h0030) begin bad++; $display("FAIL jmp_oldA: got %h want 0030", pc); end
        total++; if (addressM !== 15'd1) begin bad++; $display("FAIL jmp_newA: got %h want 0001", addressM); end
    endtask

    task automatic test_wrap_stall();
        logic [15:0] stall_ins [6];
        stall_ins = '{16'hE7C8, 16'hE7C8, 16'hE7C8, 16'hE7F8, 16'hEA87, 16'h0007};
        exec(16'h7FFF);
        instruction = 16'hEA87;
        tick();
        pc_m = 15'h7FFF;
        total++; if (pc !== 15'h7FFF) begin bad++; $display("FAIL wrap_pre: got %h want 7fff", pc); end
        exec(16'hE300);
        total++; if (pc !== 15'h0000) begin bad++; $display("FAIL wrap: got %h want 0000", pc); end
        load_d(16'h0005);
        exec(16'h0064);
        en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            instruction = stall_ins[i];
            #1;
            total++; if (writeM !== 1'b0) begin bad++; $display("FAIL stall_writeM%0d: got %b want 0", i, writeM); end
            tick();
            total++; if (pc !== pc_m || addressM !== 15'd100) begin
                bad++; $display("FAIL stall_hold%0d: got pc=%h addr=%h want %h/0064", i, pc, addressM, pc_m);
            end
        end
        en = 1'b1;
        instruction = 16'hE300;
        #1;
        total++; if (outM !== 16'd5) begin bad++; $display("FAIL stall_D: got %h want 0005", outM); end
    endtask

    task automatic test_reset_midop();
        instruction = 16'hE7C8;
        en = 1'b1;
        rst_n = 1'b0;
        #1;
        total++; if (writeM !== 1'b0) begin bad++; $display("FAIL midrst_writeM: got %b want 0", writeM); end
        tick();
        rst_n = 1'b1;
        pc_m = 15'h0000;
        total++; if (pc !== 15'h0000) begin bad++; $display("FAIL midrst_pc: got %h want 0000", pc); end
        instruction = 16'hE300;
        #1;
        total++; if (outM !== 16'h0000) begin bad++; $display("FAIL midrst_D: got %h want 0000", outM); end
        total++; if (addressM !== 15'h0000) begin bad++; $display("FAIL midrst_A: got %h want 0000", addressM); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_mem_write();
        test_jump();
        test_wrap_stall();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
